stream_test_engine: RTL and testbench
=====================================

# stream_test_engine

Parametrised traffic engine sitting between the FT245 core's user-side TX/RX FIFO ports and the rest of the design, replacing the fixed loopback test. One clock domain (the user/generated clock that also drives the core's tx_clk/rx_clk). Selectable modes: buffered loopback, counter-pattern generator, counter-pattern checker, or generator and checker concurrently. Word and error counters support host-driven throughput and integrity testing.

## Interface
- DATA_W, 32: data word width, matches the core's rx_data/tx_data.
- DEPTH, 8: loopback buffer depth in words; power of two, at least 2.
- CNT_W, 32: width of word and error counters.

- clk  in  1  engine clock.
- rst  in  1  asynchronous, active-low reset.
- mode  in  2  0 LOOPBACK, 1 GEN, 2 CHECK, 3 GEN_CHECK; sampled only in IDLE.
- enable  in  1  level; high starts/continues a run.
- clear  in  1  synchronous one-cycle pulse; flush and zero everything.
- rx_valid  in  1  core RX FIFO non-empty; rx_data is valid (first-word-fall-through).
- rx_data  in  DATA_W  core RX head word.
- rx_read  out  1  pop strobe to core RX FIFO.
- tx_ready  in  1  core TX FIFO can accept a word this cycle (the core's tx_valid).
- tx_write  out  1  push strobe to core TX FIFO.
- tx_data  out  DATA_W  word pushed with tx_write.
- busy  out  1  state is not IDLE.
- word_count  out  CNT_W  words pushed to TX since clear; wraps.
- err_count  out  CNT_W  checker mismatches since clear; saturates at all-ones.
- err_flag  out  1  sticky; set on the first mismatch, cleared by clear or reset.
- level  out  $clog2(DEPTH)+1  loopback buffer occupancy.

## Operation
- States: IDLE, RUN, DRAIN. Reset: IDLE, buffer empty, all counters, gen and expected values zero, err_flag 0.
- IDLE -> RUN when enable=1; mode is latched into active_mode on that edge.
- RUN -> DRAIN when enable=0 and active_mode is LOOPBACK with the buffer non-empty; RUN -> IDLE when enable=0 otherwise.
- DRAIN -> IDLE on the cycle the last buffered word is written (level goes 1->0 with tx_write); enable=1 during DRAIN is ignored.
- clear has priority over everything: next state IDLE, buffer flushed, counters, gen and expected values zeroed, err_flag 0; rx_read and tx_write are forced 0 in the clear cycle.
- LOOPBACK: rx_read = RUN & rx_valid & !full. tx_write = (RUN|DRAIN) & !empty & tx_ready, tx_data = buffer head. Words are unmodified and in order. rx_read never pops into a full buffer, even if a TX pop happens in the same cycle.
- GEN: tx_write = RUN & tx_ready, tx_data = gen; gen increments modulo 2^DATA_W per write. rx_read = 0.
- CHECK: rx_read = RUN & rx_valid. For each popped word, a mismatch against expected increments err_count and sets err_flag. expected becomes rx_data+1 after every popped word (resync on mismatch, so one dropped word gives one error).
- GEN_CHECK: GEN and CHECK operate independently in the same cycle.
- word_count increments on every tx_write in any mode.

## Timing
- rx_read and tx_write are combinational from state, buffer flags, rx_valid and tx_ready. There is no other combinational path from inputs to outputs.
- A loopback word popped in cycle N is written to the buffer at the end of N. The earliest tx_write for it is N+1.
- Counters, err_flag and level update at the clock edge following the qualifying strobe.
- Simultaneous push and pop leave level unchanged; pointers wrap modulo DEPTH.
- Sustained throughput in every mode is one word per clock while rx_valid and tx_ready both stay high.
- Asserting rst mid-transfer discards buffered data. Outputs take reset values asynchronously.

## Structure
- Package stream_test_pkg holds:
  - the mode encodings (MODE_LOOPBACK=0, MODE_GEN=1, MODE_CHECK=2, MODE_GEN_CHECK=3);
  - the state enum for IDLE/RUN/DRAIN.
- Sub-module stream_test_fifo: synchronous FIFO parametrised by DATA_W and DEPTH, first-word-fall-through head, with full, empty and level outputs, a flush input, and the same asynchronous active-low reset.
- The top level contains the FSM, the generator, the checker and the counters.

## Test plan
- LOOPBACK, tx_ready=1: feed 0x00000000..0x0000000F back-to-back -> identical 16 words on tx in order, first tx_write one cycle after first rx_read, word_count=16, err_count=0.
- LOOPBACK, tx_ready=0, 12 words offered, DEPTH=8 -> rx_read stops after 8, level=8, rx_valid held; then tx_ready=1 and enable=0 -> DRAIN emits 8 words, busy falls after the last, remaining 4 stay in core RX.
- GEN with tx_ready toggling 1,0 for 20 cycles -> tx_data 0,1,2,...,9 only on ready cycles, word_count=10; a start value preloaded to 0xFFFFFFFF wraps to 0 after one write.
- CHECK with input 0,1,2,4,5,5 -> err_count=2 (at 4 and second 5), err_flag=1; clear -> err_count=0, err_flag=0, expected=0.
- GEN_CHECK with external loop tx->rx through a model FIFO for 1000 words -> err_count=0, word_count=1000.
- Reset asserted mid-LOOPBACK with level=5 -> level=0, tx_write=0, rx_read=0, busy=0 immediately; after release, enable restarts cleanly.

Source files
------------

// File: rtl/stream_test_pkg.sv
// Shared encodings for the stream test engine: run modes and FSM states.
package stream_test_pkg;

    localparam logic [1:0] MODE_LOOPBACK  = 2'd0;
    localparam logic [1:0] MODE_GEN       = 2'd1;
    localparam logic [1:0] MODE_CHECK     = 2'd2;
    localparam logic [1:0] MODE_GEN_CHECK = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/stream_test_fifo.sv
// First-word-fall-through synchronous FIFO with flush and occupancy output.
module stream_test_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = AW + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [LVL_W-1:0]  level_o
);

    localparam logic [AW-1:0]    PtrOne = AW'(1);
    localparam logic [LVL_W-1:0] LvlOne = LVL_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrOne;
            if (do_pop)  rptr_q <= rptr_q + PtrOne;
            // Simultaneous push and pop leave the level unchanged
            if (do_push && !do_pop) level_q <= level_q + LvlOne;
            else if (!do_push && do_pop) level_q <= level_q - LvlOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/stream_test_engine.sv
// Traffic engine between FT245 user FIFOs: loopback, pattern generator and checker.
module stream_test_engine
    import stream_test_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = 32,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        mode_i,
    input  logic              enable_i,
    input  logic              clear_i,
    input  logic              rx_valid_i,
    input  logic [DATA_W-1:0] rx_data_i,
    output logic              rx_read_o,
    input  logic              tx_ready_i,
    output logic              tx_write_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  word_count_o,
    output logic [CNT_W-1:0]  err_count_o,
    output logic              err_flag_o,
    output logic [LVL_W-1:0]  level_o
);

    localparam logic [DATA_W-1:0] DataOne = DATA_W'(1);
    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
    localparam logic [LVL_W-1:0]  LvlOne  = LVL_W'(1);

    state_e            state_q;
    logic [1:0]        active_mode_q;
    logic [DATA_W-1:0] gen_q, exp_q;
    logic [CNT_W-1:0]  word_cnt_q, err_cnt_q;
    logic              err_flag_q;

    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              is_run, is_drain, lb_mode, gen_mode, chk_mode;
    logic              lb_push, lb_pop, chk_pop, mismatch;

    always_comb begin
        is_run     = (state_q == StRun);
        is_drain   = (state_q == StDrain);
        lb_mode    = (active_mode_q == MODE_LOOPBACK);
        gen_mode   = (active_mode_q == MODE_GEN) || (active_mode_q == MODE_GEN_CHECK);
        chk_mode   = (active_mode_q == MODE_CHECK) || (active_mode_q == MODE_GEN_CHECK);
        rx_read_o  = 1'b0;
        tx_write_o = 1'b0;
        if (!clear_i) begin
            if (lb_mode) begin
                // Never pop RX into a full buffer, even when TX pops this cycle
                rx_read_o  = is_run & rx_valid_i & ~fifo_full;
                tx_write_o = (is_run | is_drain) & ~fifo_empty & tx_ready_i;
            end else begin
                rx_read_o  = is_run & rx_valid_i & chk_mode;
                tx_write_o = is_run & tx_ready_i & gen_mode;
            end
        end
        lb_push  = lb_mode & rx_read_o;
        lb_pop   = lb_mode & tx_write_o;
        chk_pop  = chk_mode & rx_read_o;
        mismatch = chk_pop & (rx_data_i != exp_q);
    end

    assign tx_data_o    = lb_mode ? fifo_head : gen_q;
    assign busy_o       = (state_q != StIdle);
    assign word_count_o = word_cnt_q;
    assign err_count_o  = err_cnt_q;
    assign err_flag_o   = err_flag_q;
    assign level_o      = fifo_level;

    stream_test_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush_i(clear_i),
        .push_i (lb_push),
        .wdata_i(rx_data_i),
        .pop_i  (lb_pop),
        .rdata_o(fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .level_o(fifo_level)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            active_mode_q <= MODE_LOOPBACK;
            gen_q         <= '0;
            exp_q         <= '0;
            word_cnt_q    <= '0;
            err_cnt_q     <= '0;
            err_flag_q    <= 1'b0;
        end else if (clear_i) begin
            state_q    <= StIdle;
            gen_q      <= '0;
            exp_q      <= '0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable_i) begin
                        state_q       <= StRun;
                        active_mode_q <= mode_i;
                    end
                end
                StRun: begin
                    // A word pushed on the exit cycle still has to be drained
                    if (!enable_i) begin
                        state_q <= (lb_mode && (!fifo_empty || lb_push)) ? StDrain : StIdle;
                    end
                end
                StDrain: begin
                    if (fifo_empty || (fifo_level == LvlOne && lb_pop)) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (tx_write_o) word_cnt_q <= word_cnt_q + CntOne;
            if (tx_write_o && gen_mode) gen_q <= gen_q + DataOne;
            // Resync on every popped word so a dropped word costs a single error
            if (chk_pop) exp_q <= rx_data_i + DataOne;
            if (mismatch) begin
                err_flag_q <= 1'b1;
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CntOne;
            end
        end
    end

endmodule

// File: tb/tb_stream_test_engine.sv
// Directed self-checking bench for stream_test_engine with a queue-based model of the core FIFOs.
module tb_stream_test_engine;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic        enable = 1'b0, clear = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_read, tx_write, busy, err_flag;
    logic [31:0] tx_data, word_count, err_count;
    logic [3:0]  level;

    // Narrow instance used to observe generator wrap-around
    logic [1:0]  s_mode = 2'd1;
    logic        s_enable = 1'b0, s_clear = 1'b0, s_rx_valid = 1'b0, s_tx_ready = 1'b0;
    logic [3:0]  s_rx_data = '0;
    logic        s_rx_read, s_tx_write, s_busy, s_err_flag;
    logic [3:0]  s_tx_data;
    logic [7:0]  s_word_count, s_err_count;
    logic [2:0]  s_level;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] rx_q[$];
    logic [31:0] tx_q[$];
    int cyc, first_rd, first_wr;
    bit loop_en;

    always #5 clk = ~clk;

    stream_test_engine #(.DATA_W(32), .DEPTH(8), .CNT_W(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .mode_i(mode), .enable_i(enable), .clear_i(clear),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_read_o(rx_read),
        .tx_ready_i(tx_ready), .tx_write_o(tx_write), .tx_data_o(tx_data), .busy_o(busy),
        .word_count_o(word_count), .err_count_o(err_count), .err_flag_o(err_flag),
        .level_o(level)
    );

    stream_test_engine #(.DATA_W(4), .DEPTH(4), .CNT_W(8)) dut_small (
        .clk_i(clk), .rst_ni(rst_ni), .mode_i(s_mode), .enable_i(s_enable), .clear_i(s_clear),
        .rx_valid_i(s_rx_valid), .rx_data_i(s_rx_data), .rx_read_o(s_rx_read),
        .tx_ready_i(s_tx_ready), .tx_write_o(s_tx_write), .tx_data_o(s_tx_data),
        .busy_o(s_busy), .word_count_o(s_word_count), .err_count_o(s_err_count),
        .err_flag_o(s_err_flag), .level_o(s_level)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_rx();
        rx_valid = (rx_q.size() != 0);
        rx_data  = rx_valid ? rx_q[0] : 32'h0;
    endtask

    task automatic prep();
        rx_q.delete();
        tx_q.delete();
        cyc = 0;
        first_rd = -1;
        first_wr = -1;
        loop_en = 1'b0;
        set_rx();
    endtask

    // One clock: sample strobes mid-cycle, then update the core FIFO model after the edge
    task automatic step();
        logic rd, wr;
        logic [31:0] d;
        @(negedge clk);
        rd = rx_read;
        wr = tx_write;
        d  = tx_data;
        if (rd && first_rd < 0) first_rd = cyc;
        if (wr && first_wr < 0) first_wr = cyc;
        @(posedge clk);
        #1;
        if (rd && rx_q.size() != 0) rx_q.delete(0);
        if (wr) begin
            tx_q.push_back(d);
            if (loop_en) rx_q.push_back(d);
        end
        set_rx();
        cyc++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({rx_read, tx_write} !== 2'b00) begin
            tests_failed++;
            $display("FAIL clear_strobes: got %b, expected 00", {rx_read, tx_write});
        end
        @(posedge clk);
        #1;
        clear = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        rx_valid = 1'b1;
        tx_ready = 1'b1;
        #12;
        tests_run++;
        if ({busy, err_flag, rx_read, tx_write} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, expected 0000", {busy, err_flag, rx_read, tx_write});
        end
        tests_run++;
        if (level !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_level: got %0d, expected 0", level);
        end
        tests_run++;
        if (word_count !== 32'd0 || err_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_counts: got %0d/%0d, expected 0/0", word_count, err_count);
        end
        @(negedge clk);
        rst_ni = 1'b1;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_loopback();
        int n;
        prep();
        do_clear();
        for (int i = 0; i < 16; i++) rx_q.push_back(32'(i));
        set_rx();
        mode = 2'd0;
        tx_ready = 1'b1;
        enable = 1'b1;
        n = 0;
        while (tx_q.size() < 16 && n < 40) begin
            step();
            n++;
        end
        enable = 1'b0;
        step();
        tests_run++;
        if (tx_q.size() != 16) begin
            tests_failed++;
            $display("FAIL lb_count: got %0d words, expected 16", tx_q.size());
        end
        for (int i = 0; i < 16 && i < tx_q.size(); i++) begin
            tests_run++;
            if (tx_q[i] !== 32'(i)) begin
                tests_failed++;
                $display("FAIL lb_word[%0d]: got %h, expected %h", i, tx_q[i], 32'(i));
            end
        end
        tests_run++;
        if (first_wr - first_rd != 1) begin
            tests_failed++;
            $display("FAIL lb_latency: got %0d cycles, expected 1", first_wr - first_rd);
        end
        tests_run++;
        if (word_count !== 32'd16 || err_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL lb_counters: got %0d/%0d, expected 16/0", word_count, err_count);
        end
        tests_run++;
        if (busy !== 1'b0 || level !== 4'd0) begin
            tests_failed++;
            $display("FAIL lb_idle: got busy=%b level=%0d, expected 0/0", busy, level);
        end
    endtask

    task automatic test_backpressure();
        int n;
        prep();
        do_clear();
        for (int i = 0; i < 12; i++) rx_q.push_back(32'(100 + i));
        set_rx();
        mode = 2'd0;
        tx_ready = 1'b0;
        enable = 1'b1;
        repeat (15) step();
        tests_run++;
        if (level !== 4'd8 || rx_q.size() != 4 || rx_valid !== 1'b1 || tx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_full: got level=%0d rxleft=%0d tx=%0d, expected 8/4/0",
                     level, rx_q.size(), tx_q.size());
        end
        tx_ready = 1'b1;
        enable = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (n != 8) begin
            tests_failed++;
            $display("FAIL bp_drain_cycles: got %0d, expected 8", n);
        end
        tests_run++;
        if (tx_q.size() != 8) begin
            tests_failed++;
            $display("FAIL bp_drain_count: got %0d, expected 8", tx_q.size());
        end
        for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
            tests_run++;
            if (tx_q[i] !== 32'(100 + i)) begin
                tests_failed++;
                $display("FAIL bp_word[%0d]: got %0d, expected %0d", i, tx_q[i], 100 + i);
            end
        end
        tests_run++;
        if (rx_q.size() != 4 || level !== 4'd0 || word_count !== 32'd8) begin
            tests_failed++;
            $display("FAIL bp_after: got rxleft=%0d level=%0d wc=%0d, expected 4/0/8",
                     rx_q.size(), level, word_count);
        end
    endtask

    task automatic test_gen();
        prep();
        do_clear();
        for (int i = 0; i < 3; i++) rx_q.push_back(32'hA0 + 32'(i));
        set_rx();
        mode = 2'd1;
        tx_ready = 1'b0;
        enable = 1'b1;
        step();
        mode = 2'd0;
        for (int i = 0; i < 20; i++) begin
            tx_ready = (i % 2 == 0);
            step();
        end
        tests_run++;
        if (tx_q.size() != 10) begin
            tests_failed++;
            $display("FAIL gen_count: got %0d, expected 10", tx_q.size());
        end
        for (int i = 0; i < 10 && i < tx_q.size(); i++) begin
            tests_run++;
            if (tx_q[i] !== 32'(i)) begin
                tests_failed++;
                $display("FAIL gen_word[%0d]: got %0d, expected %0d", i, tx_q[i], i);
            end
        end
        tests_run++;
        if (word_count !== 32'd10 || rx_q.size() != 3) begin
            tests_failed++;
            $display("FAIL gen_counters: got wc=%0d rxleft=%0d, expected 10/3",
                     word_count, rx_q.size());
        end
        tx_ready = 1'b1;
        do_clear();
        tests_run++;
        if (word_count !== 32'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL gen_clear: got wc=%0d busy=%b, expected 0/0", word_count, busy);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_gen_wrap();
        logic [3:0] sq[$];
        s_mode = 2'd1;
        s_tx_ready = 1'b1;
        s_enable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (s_tx_write) sq.push_back(s_tx_data);
            @(posedge clk);
            #1;
        end
        s_enable = 1'b0;
        tests_run++;
        if (sq.size() != 19) begin
            tests_failed++;
            $display("FAIL wrap_count: got %0d, expected 19", sq.size());
        end else begin
            tests_run++;
            if (sq[15] !== 4'hF || sq[16] !== 4'h0 || sq[17] !== 4'h1) begin
                tests_failed++;
                $display("FAIL wrap_values: got %h %h %h, expected f 0 1", sq[15], sq[16], sq[17]);
            end
        end
        tests_run++;
        if (s_word_count !== 8'd19) begin
            tests_failed++;
            $display("FAIL wrap_word_count: got %0d, expected 19", s_word_count);
        end
    endtask

    task automatic test_check();
        int n;
        prep();
        do_clear();
        rx_q.push_back(32'd0); rx_q.push_back(32'd1); rx_q.push_back(32'd2);
        rx_q.push_back(32'd4); rx_q.push_back(32'd5); rx_q.push_back(32'd5);
        rx_q.push_back(32'd6);
        set_rx();
        mode = 2'd2;
        tx_ready = 1'b1;
        enable = 1'b1;
        n = 0;
        while (rx_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        tests_run++;
        if (err_count !== 32'd2 || err_flag !== 1'b1) begin
            tests_failed++;
            $display("FAIL chk_errors: got cnt=%0d flag=%b, expected 2/1", err_count, err_flag);
        end
        tests_run++;
        if (word_count !== 32'd0 || rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL chk_side: got wc=%0d rxleft=%0d, expected 0/0", word_count, rx_q.size());
        end
        enable = 1'b0;
        step();
        do_clear();
        tests_run++;
        if (err_count !== 32'd0 || err_flag !== 1'b0) begin
            tests_failed++;
            $display("FAIL chk_clear: got cnt=%0d flag=%b, expected 0/0", err_count, err_flag);
        end
        for (int i = 0; i < 3; i++) rx_q.push_back(32'(i));
        set_rx();
        enable = 1'b1;
        n = 0;
        while (rx_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        enable = 1'b0;
        step();
        tests_run++;
        if (err_count !== 32'd0 || err_flag !== 1'b0 || rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL chk_restart: got cnt=%0d flag=%b rxleft=%0d, expected 0/0/0",
                     err_count, err_flag, rx_q.size());
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_gen_check();
        int n;
        prep();
        do_clear();
        loop_en = 1'b1;
        mode = 2'd3;
        tx_ready = 1'b1;
        enable = 1'b1;
        step();
        n = 0;
        while (tx_q.size() < 1000 && n < 1100) begin
            step();
            n++;
        end
        enable = 1'b0;
        tx_ready = 1'b0;
        step();
        step();
        tests_run++;
        if (n != 1000) begin
            tests_failed++;
            $display("FAIL gc_throughput: got %0d cycles, expected 1000", n);
        end
        tests_run++;
        if (word_count !== 32'd1000) begin
            tests_failed++;
            $display("FAIL gc_word_count: got %0d, expected 1000", word_count);
        end
        tests_run++;
        if (err_count !== 32'd0 || err_flag !== 1'b0 || rx_q.size() != 0) begin
            tests_failed++;
            $display("FAIL gc_errors: got cnt=%0d flag=%b rxleft=%0d, expected 0/0/0",
                     err_count, err_flag, rx_q.size());
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL gc_idle: got busy=%b, expected 0", busy);
        end
        loop_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        prep();
        do_clear();
        for (int i = 0; i < 5; i++) rx_q.push_back(32'(200 + i));
        set_rx();
        mode = 2'd0;
        tx_ready = 1'b0;
        enable = 1'b1;
        repeat (8) step();
        tests_run++;
        if (level !== 4'd5) begin
            tests_failed++;
            $display("FAIL rst_pre_level: got %0d, expected 5", level);
        end
        rst_ni = 1'b0;
        rx_q.delete();
        for (int i = 0; i < 3; i++) rx_q.push_back(32'(300 + i));
        set_rx();
        tx_ready = 1'b1;
        #1;
        tests_run++;
        if (level !== 4'd0) begin
            tests_failed++;
            $display("FAIL rst_level: got %0d, expected 0", level);
        end
        tests_run++;
        if ({busy, rx_read, tx_write} !== 3'b000) begin
            tests_failed++;
            $display("FAIL rst_strobes: got %b, expected 000", {busy, rx_read, tx_write});
        end
        #2;
        rst_ni = 1'b1;
        tx_q.delete();
        n = 0;
        while (tx_q.size() < 3 && n < 20) begin
            step();
            n++;
        end
        enable = 1'b0;
        step();
        step();
        tests_run++;
        if (tx_q.size() != 3) begin
            tests_failed++;
            $display("FAIL rst_restart_count: got %0d, expected 3", tx_q.size());
        end
        for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
            tests_run++;
            if (tx_q[i] !== 32'(300 + i)) begin
                tests_failed++;
                $display("FAIL rst_word[%0d]: got %0d, expected %0d", i, tx_q[i], 300 + i);
            end
        end
        tests_run++;
        if (word_count !== 32'd3 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_restart_state: got wc=%0d busy=%b, expected 3/0", word_count, busy);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_backpressure();
        test_gen();
        test_gen_wrap();
        test_check();
        test_gen_check();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
